// File: rtl/id_ex_stage_reg.sv
// rtl/id_ex_stage_reg.sv - ID/EX pipeline register with load-use hazard detection
//
// Captures the decoded control bundle and operands from ID into EX, one cycle
// of latency. A load in EX whose rt matches a source field of the instruction
// in ID freezes PC and IF/ID (stall_o) and puts a bubble into EX. A hold from a
// later stage (stallE_i) freezes this register. A flush (flush_i) loads a bubble.
// bubble_cnt_o counts hazard bubbles and saturates at all-ones.
//
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   stallE_i, flush_i    hold / kill requests from downstream control
//   id_*                 decoded instruction from ID (valid, control, data, fields)
//   stall_o              freeze PC and IF/ID this cycle
//   ex_*                 registered copy of the id_* bundle seen by EX
//   bubble_cnt_o         saturating count of load-use bubbles
module id_ex_stage_reg #(
  parameter int          DATA_W   = 32,
  parameter int          ALU_OP_W = 4,
  parameter logic [1:0]  LOAD_SRC = 2'b10,
  parameter int          CNT_W    = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                stallE_i,
  input  logic                flush_i,
  input  logic                id_valid_i,
  input  logic                id_regWe_i,
  input  logic                id_memWe_i,
  input  logic [ALU_OP_W-1:0] id_aluOp_i,
  input  logic                id_aluSrc1_i,
  input  logic                id_aluSrc2_i,
  input  logic [1:0]          id_regSrc_i,
  input  logic [1:0]          id_regDst_i,
  input  logic [DATA_W-1:0]   id_pc_i,
  input  logic [DATA_W-1:0]   id_rsData_i,
  input  logic [DATA_W-1:0]   id_rtData_i,
  input  logic [DATA_W-1:0]   id_imm_i,
  input  logic [4:0]          id_rs_i,
  input  logic [4:0]          id_rt_i,
  input  logic [4:0]          id_rd_i,
  input  logic [4:0]          id_shamt_i,
  output logic                stall_o,
  output logic                ex_valid_o,
  output logic                ex_regWe_o,
  output logic                ex_memWe_o,
  output logic [ALU_OP_W-1:0] ex_aluOp_o,
  output logic                ex_aluSrc1_o,
  output logic                ex_aluSrc2_o,
  output logic [1:0]          ex_regSrc_o,
  output logic [1:0]          ex_regDst_o,
  output logic [DATA_W-1:0]   ex_pc_o,
  output logic [DATA_W-1:0]   ex_rsData_o,
  output logic [DATA_W-1:0]   ex_rtData_o,
  output logic [DATA_W-1:0]   ex_imm_o,
  output logic [4:0]          ex_rs_o,
  output logic [4:0]          ex_rt_o,
  output logic [4:0]          ex_rd_o,
  output logic [4:0]          ex_shamt_o,
  output logic [CNT_W-1:0]    bubble_cnt_o
);

  logic hz;
  logic bubble;

  // Conservative: both rs and rt are compared whether or not ID actually reads them.
  // A load into $zero never produces a value worth waiting for.
  assign hz = ex_valid_o && (ex_regSrc_o == LOAD_SRC) && (ex_rt_o != 5'd0) && id_valid_i &&
              ((ex_rt_o == id_rs_i) || (ex_rt_o == id_rt_i));

  assign stall_o = hz | stallE_i;
  assign bubble  = flush_i | hz;

  always_ff @(posedge clk) begin
    if (rst || (!stallE_i && bubble)) begin
      ex_valid_o   <= 1'b0;
      ex_regWe_o   <= 1'b0;
      ex_memWe_o   <= 1'b0;
      ex_aluOp_o   <= '0;
      ex_aluSrc1_o <= 1'b0;
      ex_aluSrc2_o <= 1'b0;
      ex_regSrc_o  <= '0;
      ex_regDst_o  <= '0;
      ex_pc_o      <= '0;
      ex_rsData_o  <= '0;
      ex_rtData_o  <= '0;
      ex_imm_o     <= '0;
      ex_rs_o      <= '0;
      ex_rt_o      <= '0;
      ex_rd_o      <= '0;
      ex_shamt_o   <= '0;
    end else if (!stallE_i) begin
      ex_valid_o   <= id_valid_i;
      ex_regWe_o   <= id_regWe_i;
      ex_memWe_o   <= id_memWe_i;
      ex_aluOp_o   <= id_aluOp_i;
      ex_aluSrc1_o <= id_aluSrc1_i;
      ex_aluSrc2_o <= id_aluSrc2_i;
      ex_regSrc_o  <= id_regSrc_i;
      ex_regDst_o  <= id_regDst_i;
      ex_pc_o      <= id_pc_i;
      ex_rsData_o  <= id_rsData_i;
      ex_rtData_o  <= id_rtData_i;
      ex_imm_o     <= id_imm_i;
      ex_rs_o      <= id_rs_i;
      ex_rt_o      <= id_rt_i;
      ex_rd_o      <= id_rd_i;
      ex_shamt_o   <= id_shamt_i;
    end
  end

  // Only bubbles caused by the hazard itself are counted; a flush takes priority
  // and a downstream hold means no bubble is inserted at all.
  always_ff @(posedge clk) begin
    if (rst) begin
      bubble_cnt_o <= '0;
    end else if (!stallE_i && !flush_i && hz && (bubble_cnt_o != {CNT_W{1'b1}})) begin
      bubble_cnt_o <= bubble_cnt_o + 1'b1;
    end
  end

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// tb/tb_id_ex_stage_reg.sv - directed vector bench for id_ex_stage_reg
module tb_id_ex_stage_reg;

  logic        clk = 1'b0;
  logic        rst, stallE, flush, id_valid, id_regWe, id_memWe, id_aluSrc1, id_aluSrc2;
  logic [3:0]  id_aluOp;
  logic [1:0]  id_regSrc, id_regDst;
  logic [31:0] id_pc, id_rsData, id_rtData, id_imm;
  logic [4:0]  id_rs, id_rt, id_rd, id_shamt;

  logic        stall, ex_valid, ex_regWe, ex_memWe, ex_aluSrc1, ex_aluSrc2;
  logic [3:0]  ex_aluOp;
  logic [1:0]  ex_regSrc, ex_regDst;
  logic [31:0] ex_pc, ex_rsData, ex_rtData, ex_imm;
  logic [4:0]  ex_rs, ex_rt, ex_rd, ex_shamt;
  logic [15:0] bubble_cnt;

  logic        s_stall, s_valid, s_regWe, s_memWe, s_aluSrc1, s_aluSrc2;
  logic [3:0]  s_aluOp;
  logic [1:0]  s_regSrc, s_regDst;
  logic [31:0] s_pc, s_rsData, s_rtData, s_imm;
  logic [4:0]  s_rs, s_rt, s_rd, s_shamt;
  logic [1:0]  s_cnt;

  always #5 clk = ~clk;

  id_ex_stage_reg dut (
    .clk(clk), .rst(rst), .stallE_i(stallE), .flush_i(flush), .id_valid_i(id_valid),
    .id_regWe_i(id_regWe), .id_memWe_i(id_memWe), .id_aluOp_i(id_aluOp),
    .id_aluSrc1_i(id_aluSrc1), .id_aluSrc2_i(id_aluSrc2), .id_regSrc_i(id_regSrc),
    .id_regDst_i(id_regDst), .id_pc_i(id_pc), .id_rsData_i(id_rsData), .id_rtData_i(id_rtData),
    .id_imm_i(id_imm), .id_rs_i(id_rs), .id_rt_i(id_rt), .id_rd_i(id_rd), .id_shamt_i(id_shamt),
    .stall_o(stall), .ex_valid_o(ex_valid), .ex_regWe_o(ex_regWe), .ex_memWe_o(ex_memWe),
    .ex_aluOp_o(ex_aluOp), .ex_aluSrc1_o(ex_aluSrc1), .ex_aluSrc2_o(ex_aluSrc2),
    .ex_regSrc_o(ex_regSrc), .ex_regDst_o(ex_regDst), .ex_pc_o(ex_pc), .ex_rsData_o(ex_rsData),
    .ex_rtData_o(ex_rtData), .ex_imm_o(ex_imm), .ex_rs_o(ex_rs), .ex_rt_o(ex_rt),
    .ex_rd_o(ex_rd), .ex_shamt_o(ex_shamt), .bubble_cnt_o(bubble_cnt)
  );

  id_ex_stage_reg #(.CNT_W(2)) dut_s (
    .clk(clk), .rst(rst), .stallE_i(stallE), .flush_i(flush), .id_valid_i(id_valid),
    .id_regWe_i(id_regWe), .id_memWe_i(id_memWe), .id_aluOp_i(id_aluOp),
    .id_aluSrc1_i(id_aluSrc1), .id_aluSrc2_i(id_aluSrc2), .id_regSrc_i(id_regSrc),
    .id_regDst_i(id_regDst), .id_pc_i(id_pc), .id_rsData_i(id_rsData), .id_rtData_i(id_rtData),
    .id_imm_i(id_imm), .id_rs_i(id_rs), .id_rt_i(id_rt), .id_rd_i(id_rd), .id_shamt_i(id_shamt),
    .stall_o(s_stall), .ex_valid_o(s_valid), .ex_regWe_o(s_regWe), .ex_memWe_o(s_memWe),
    .ex_aluOp_o(s_aluOp), .ex_aluSrc1_o(s_aluSrc1), .ex_aluSrc2_o(s_aluSrc2),
    .ex_regSrc_o(s_regSrc), .ex_regDst_o(s_regDst), .ex_pc_o(s_pc), .ex_rsData_o(s_rsData),
    .ex_rtData_o(s_rtData), .ex_imm_o(s_imm), .ex_rs_o(s_rs), .ex_rt_o(s_rt),
    .ex_rd_o(s_rd), .ex_shamt_o(s_shamt), .bubble_cnt_o(s_cnt)
  );

  typedef struct {
    logic        rst, stl, fl, v, we, mwe;
    logic [1:0]  src, dst;
    logic [4:0]  rs, rt;
    logic [31:0] pc;
    logic        cs, x_stall, x_valid, x_we, x_mwe;
    logic [1:0]  x_src, x_dst;
    logic [4:0]  x_rs, x_rt;
    logic [31:0] x_pc;
    logic [15:0] x_cnt;
    logic [1:0]  x_cnts;
  } vec_t;

  int   applied = 0;
  int   errors  = 0;
  vec_t tbl[20];
  vec_t t;
  int   exp_cnt, exp_cnts;
  logic [31:0] pcb;

  function automatic vec_t mk(int rst_, int stl, int fl, int v, int we, int mwe, int src, int dst,
                              int rs, int rt, logic [31:0] pc, int cs, int xs, int xv, int xwe,
                              int xmwe, int xsrc, int xdst, int xrs, int xrt, logic [31:0] xpc,
                              int xcnt, int xcnts);
    vec_t r;
    r.rst = 1'(rst_); r.stl = 1'(stl); r.fl = 1'(fl); r.v = 1'(v); r.we = 1'(we); r.mwe = 1'(mwe);
    r.src = 2'(src); r.dst = 2'(dst); r.rs = 5'(rs); r.rt = 5'(rt); r.pc = pc;
    r.cs = 1'(cs); r.x_stall = 1'(xs); r.x_valid = 1'(xv); r.x_we = 1'(xwe); r.x_mwe = 1'(xmwe);
    r.x_src = 2'(xsrc); r.x_dst = 2'(xdst); r.x_rs = 5'(xrs); r.x_rt = 5'(xrt); r.x_pc = xpc;
    r.x_cnt = 16'(xcnt); r.x_cnts = 2'(xcnts);
    return r;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    if (act !== exp) begin
      errors++;
      $display("FAIL vec %0d %s: got %h expected %h", applied, name, act, exp);
    end
  endtask

  // Remaining operand fields are derived from the PC so a bubble (pc=0) zeroes all of them.
  task automatic apply(vec_t v);
    rst = v.rst; stallE = v.stl; flush = v.fl; id_valid = v.v;
    id_regWe = v.we; id_memWe = v.mwe; id_regSrc = v.src; id_regDst = v.dst;
    id_rs = v.rs; id_rt = v.rt; id_pc = v.pc;
    id_aluOp = v.pc[3:0]; id_aluSrc1 = v.pc[8]; id_aluSrc2 = v.pc[9];
    id_rsData = v.pc << 1; id_rtData = v.pc >> 1; id_imm = {v.pc[15:0], v.pc[31:16]};
    id_rd = v.pc[6:2]; id_shamt = v.pc[11:7];
    #1;
    if (v.cs) begin
      chk("stall", 32'(stall), 32'(v.x_stall));
      chk("stall_s", 32'(s_stall), 32'(v.x_stall));
    end
    @(posedge clk);
    #1;
    chk("ex_valid", 32'(ex_valid), 32'(v.x_valid));
    chk("ex_regWe", 32'(ex_regWe), 32'(v.x_we));
    chk("ex_memWe", 32'(ex_memWe), 32'(v.x_mwe));
    chk("ex_regSrc", 32'(ex_regSrc), 32'(v.x_src));
    chk("ex_regDst", 32'(ex_regDst), 32'(v.x_dst));
    chk("ex_rs", 32'(ex_rs), 32'(v.x_rs));
    chk("ex_rt", 32'(ex_rt), 32'(v.x_rt));
    chk("ex_pc", ex_pc, v.x_pc);
    chk("ex_aluOp", 32'(ex_aluOp), 32'(v.x_pc[3:0]));
    chk("ex_aluSrc1", 32'(ex_aluSrc1), 32'(v.x_pc[8]));
    chk("ex_aluSrc2", 32'(ex_aluSrc2), 32'(v.x_pc[9]));
    chk("ex_rsData", ex_rsData, v.x_pc << 1);
    chk("ex_rtData", ex_rtData, v.x_pc >> 1);
    chk("ex_imm", ex_imm, {v.x_pc[15:0], v.x_pc[31:16]});
    chk("ex_rd", 32'(ex_rd), 32'(v.x_pc[6:2]));
    chk("ex_shamt", 32'(ex_shamt), 32'(v.x_pc[11:7]));
    chk("bubble_cnt", 32'(bubble_cnt), 32'(v.x_cnt));
    chk("bubble_cnt_sat", 32'(s_cnt), 32'(v.x_cnts));
    chk("s_valid", 32'(s_valid), 32'(v.x_valid));
    applied++;
  endtask

  initial begin
    //          rst stl fl v we mwe src dst rs rt pc            cs xs xv xwe xmwe xsrc xdst xrs xrt xpc         cnt cnts
    tbl[0]  = mk(1, 0, 0, 1, 1, 1, 2, 3, 8, 8, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 0, 0);
    tbl[1]  = mk(1, 0, 0, 1, 1, 1, 2, 3, 8, 8, 32'hDEADBEEF, 1, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 0, 0);
    tbl[2]  = mk(0, 0, 0, 1, 1, 0, 1, 2, 9, 10, 32'h00400010, 1, 0, 1, 1, 0, 1, 2, 9, 10, 32'h00400010, 0, 0);
    tbl[3]  = mk(0, 0, 0, 1, 1, 0, 2, 0, 29, 8, 32'h00400014, 1, 0, 1, 1, 0, 2, 0, 29, 8, 32'h00400014, 0, 0);
    tbl[4]  = mk(0, 0, 0, 1, 1, 0, 1, 2, 8, 9, 32'h00400018, 1, 1, 0, 0, 0, 0, 0, 0, 0, 32'h0, 1, 1);
    tbl[5]  = mk(0, 0, 0, 1, 1, 0, 1, 2, 8, 9, 32'h00400018, 1, 0, 1, 1, 0, 1, 2, 8, 9, 32'h00400018, 1, 1);
    tbl[6]  = mk(0, 0, 0, 1, 1, 0, 2, 0, 29, 0, 32'h0040001C, 1, 0, 1, 1, 0, 2, 0, 29, 0, 32'h0040001C, 1, 1);
    tbl[7]  = mk(0, 0, 0, 1, 1, 0, 1, 2, 0, 5, 32'h00400020, 1, 0, 1, 1, 0, 1, 2, 0, 5, 32'h00400020, 1, 1);
    tbl[8]  = mk(0, 0, 0, 1, 1, 0, 2, 0, 1, 8, 32'h00400024, 1, 0, 1, 1, 0, 2, 0, 1, 8, 32'h00400024, 1, 1);
    tbl[9]  = mk(0, 1, 0, 1, 1, 0, 1, 2, 8, 3, 32'h00400028, 1, 1, 1, 1, 0, 2, 0, 1, 8, 32'h00400024, 1, 1);
    tbl[10] = mk(0, 1, 0, 1, 1, 0, 1, 2, 8, 3, 32'h00400028, 1, 1, 1, 1, 0, 2, 0, 1, 8, 32'h00400024, 1, 1);
    tbl[11] = mk(0, 1, 0, 1, 1, 0, 1, 2, 8, 3, 32'h00400028, 1, 1, 1, 1, 0, 2, 0, 1, 8, 32'h00400024, 1, 1);
    tbl[12] = mk(0, 0, 0, 1, 1, 0, 1, 2, 8, 3, 32'h00400028, 1, 1, 0, 0, 0, 0, 0, 0, 0, 32'h0, 2, 2);
    tbl[13] = mk(0, 0, 0, 1, 1, 0, 1, 2, 8, 3, 32'h00400028, 1, 0, 1, 1, 0, 1, 2, 8, 3, 32'h00400028, 2, 2);
    tbl[14] = mk(0, 0, 0, 1, 1, 0, 2, 0, 1, 7, 32'h0040002C, 1, 0, 1, 1, 0, 2, 0, 1, 7, 32'h0040002C, 2, 2);
    tbl[15] = mk(0, 0, 1, 1, 1, 0, 1, 2, 2, 7, 32'h00400030, 1, 1, 0, 0, 0, 0, 0, 0, 0, 32'h0, 2, 2);
    tbl[16] = mk(0, 0, 1, 1, 0, 1, 0, 0, 2, 4, 32'h00400034, 1, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 2, 2);
    tbl[17] = mk(0, 0, 0, 1, 0, 1, 0, 0, 2, 4, 32'h00400034, 1, 0, 1, 0, 1, 0, 0, 2, 4, 32'h00400034, 2, 2);
    tbl[18] = mk(0, 0, 0, 1, 1, 0, 2, 0, 3, 6, 32'h00400038, 1, 0, 1, 1, 0, 2, 0, 3, 6, 32'h00400038, 2, 2);
    tbl[19] = mk(0, 0, 0, 0, 0, 0, 0, 0, 6, 1, 32'h0040003C, 1, 0, 0, 0, 0, 0, 0, 6, 1, 32'h0040003C, 2, 2);

    for (int i = 0; i < 20; i++) apply(tbl[i]);

    // Five load-use pairs: the wide counter keeps counting, the 2-bit one sticks at 3.
    exp_cnt = 2;
    exp_cnts = 2;
    for (int k = 0; k < 5; k++) begin
      pcb = 32'h00400100 + 32'(k * 16);
      apply(mk(0, 0, 0, 1, 1, 0, 2, 0, 1, 8, pcb, 1, 0, 1, 1, 0, 2, 0, 1, 8, pcb, exp_cnt, exp_cnts));
      exp_cnt = exp_cnt + 1;
      if (exp_cnts != 3) exp_cnts = exp_cnts + 1;
      apply(mk(0, 0, 0, 1, 1, 0, 1, 2, 4, 8, pcb + 4, 1, 1, 0, 0, 0, 0, 0, 0, 0, 32'h0, exp_cnt, exp_cnts));
      apply(mk(0, 0, 0, 1, 1, 0, 1, 2, 4, 8, pcb + 4, 1, 0, 1, 1, 0, 1, 2, 4, 8, pcb + 4, exp_cnt, exp_cnts));
    end

    // Hold beats flush: the ADD from the last pair stays in EX.
    pcb = 32'h00400144;
    apply(mk(0, 1, 1, 1, 0, 1, 0, 0, 9, 9, 32'h00400200, 1, 1, 1, 1, 0, 1, 2, 4, 8, pcb, 7, 3));
    // Reset overrides hold and flush and clears both counters.
    apply(mk(1, 1, 1, 1, 1, 1, 2, 3, 8, 8, 32'hCAFEF00D, 1, 1, 0, 0, 0, 0, 0, 0, 0, 32'h0, 0, 0));

    $display("== %0d vectors applied, %0d miscompares ==", applied, errors);
    $finish;
  end

endmodule

// File: doc/id_ex_stage_reg.md
Name: id_ex_stage_reg

Overview:
ID/EX pipeline register sitting directly downstream of the decode-stage control unit. It captures the decoded control bundle (register-file write enable, data-memory write enable, ALU op, ALU source selects, write-back source and destination selects) and the operands into the EX stage. It also detects load-use hazards, freezing upstream and inserting bubbles. It honours hold and flush requests and keeps a saturating bubble counter for performance debug.

Parameters:
DATA_W, 32, operand/PC width
ALU_OP_W, 4, ALU op width
LOAD_SRC, 2'b10, regSrc encoding meaning "write-back from data memory"
CNT_W, 16, bubble counter width

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous active-high reset
stallE_i  in  1  later stage requests ID/EX hold
flush_i  in  1  kill the instruction entering EX
id_valid_i  in  1  ID holds a real instruction
id_regWe_i  in  1  register-file write enable from decode
id_memWe_i  in  1  data-memory write enable from decode
id_aluOp_i  in  ALU_OP_W  ALU op
id_aluSrc1_i  in  1  ALU source 1 select
id_aluSrc2_i  in  1  ALU source 2 select
id_regSrc_i  in  2  write-back source select
id_regDst_i  in  2  destination register select
id_pc_i  in  DATA_W  PC of the ID instruction
id_rsData_i, id_rtData_i, id_imm_i  in  DATA_W  operands and extended immediate
id_rs_i, id_rt_i, id_rd_i, id_shamt_i  in  5  register fields
stall_o  out  1  freeze PC and IF/ID this cycle
ex_valid_o  out  1  EX holds a real instruction
ex_regWe_o, ex_memWe_o, ex_aluOp_o, ex_aluSrc1_o, ex_aluSrc2_o, ex_regSrc_o, ex_regDst_o  out  as inputs  registered control
ex_pc_o, ex_rsData_o, ex_rtData_o, ex_imm_o  out  DATA_W  registered data
ex_rs_o, ex_rt_o, ex_rd_o, ex_shamt_o  out  5  registered fields
bubble_cnt_o  out  CNT_W  saturating count of inserted bubbles

Behaviour:
- Reset (rst=1 at edge): every ex_* output is 0 (ex_valid_o=0), bubble_cnt_o=0. Reset overrides all other inputs.
- Hazard (combinational): hz = ex_valid_o & (ex_regSrc_o==LOAD_SRC) & (ex_rt_o!=0) & id_valid_i & (ex_rt_o==id_rs_i | ex_rt_o==id_rt_i). The rs and rt comparison is conservative and does not check whether the source is used.
- stall_o = hz | stallE_i (combinational, same cycle).
- Per-edge update, priority order:
  1. stallE_i=1: hold all ex_* registers unchanged. The counter does not increment. The hazard is re-evaluated after release.
  2. flush_i=1: load a bubble: all control outputs 0, ex_valid_o=0, data fields 0. The counter does not increment.
  3. hz=1: load a bubble as in 2. The counter increments.
  4. Otherwise: load all id_* inputs. ex_valid_o=id_valid_i.
- A bubble must never carry regWe=1 or memWe=1.
- Latency: exactly one cycle from id_* to ex_* when not stalled.
- Load-use: exactly one bubble per dependent load. On the cycle after the bubble, ex_valid_o=0, so hz=0 and the held ID instruction advances.
- Counter saturates at all-ones and does not wrap.
- If flush_i and hz are both high: flush wins. No count; stall_o still reflects hz.
- The $zero destination (ex_rt_o=0) never causes a stall.

Test Plan:
- Reset: rst=1 for 2 cycles with random inputs -> all ex_* = 0, stall_o=0, bubble_cnt_o=0.
- Pass-through: ADD bundle (regWe=1, aluOp=4'b0000, regSrc=01, regDst=10), pc=0x00400010 -> appears on ex_* one cycle later. stall_o stays 0.
- Load-use: LW with rt=8 (regSrc=10) then ADD with rs=8 -> stall_o=1 for one cycle, EX gets a bubble, bubble_cnt_o=1, ADD enters EX on the next cycle. The same sequence with rt=0 gives no stall.
- Hold: assert stallE_i for 3 cycles mid-stream -> ex_* frozen, stall_o=1, counter unchanged. Flow resumes on release.
- Flush with hazard: flush_i=1 while hz=1 -> bubble loaded, bubble_cnt_o unchanged. Flush alone with memWe=1 (SW) in ID -> ex_memWe_o=0.
- Saturation: CNT_W=2, 5 load-use pairs -> bubble_cnt_o sticks at 3.
